// File: rtl/msi_pkg.sv
// Shared types for the MSI coherence controller: line states, bus opcodes
// and the request FSM states.
package msi_pkg;

   typedef enum logic [1:0] {
      INVALID  = 2'b00,
      SHARED   = 2'b01,
      MODIFIED = 2'b10
   } line_state_t;

   typedef enum logic [1:0] {
      READ_MISS  = 2'b00,
      INVALIDATE = 2'b01,
      WRITE_MISS = 2'b10,
      RESERVED   = 2'b11
   } bus_op_t;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } ctrl_state_t;

   // Op needed to obtain the wanted permission from the line's present state.
   function automatic bus_op_t miss_op(line_state_t cur, logic is_write);
      if (!is_write)
         return READ_MISS;
      else if (cur == SHARED)
         return INVALIDATE;
      else
         return WRITE_MISS;
   endfunction

endpackage

// File: rtl/msi_snoop_next.sv
// Snoop transition table: next state of a line, write-back and protocol
// error flags for one snooped bus op.
module msi_snoop_next
   import msi_pkg::*;
(
   input  logic [1:0] cur_state,
   input  logic [1:0] op,
   output logic [1:0] next_state,
   output logic       wb,
   output logic       err
);

   line_state_t cur;
   bus_op_t     sop;
   line_state_t nxt;

   assign cur = line_state_t'(cur_state);
   assign sop = bus_op_t'(op);

   always_comb begin
      nxt = cur;
      wb  = 1'b0;
      err = 1'b0;
      if (sop == RESERVED) begin
         err = 1'b1;
      end else begin
         case (cur)
            MODIFIED: begin
               case (sop)
                  READ_MISS:  begin nxt = SHARED;  wb = 1'b1; end
                  WRITE_MISS: begin nxt = INVALID; wb = 1'b1; end
                  default:    err = 1'b1;
               endcase
            end
            SHARED: begin
               if (sop != READ_MISS)
                  nxt = INVALID;
            end
            default: ;
         endcase
      end
   end

   assign next_state = nxt;

endmodule

// File: rtl/msi_coherence_ctrl.sv
// MSI coherence controller for a private cache: per-line state, CPU request
// FSM with bus request/grant handshake, and snoop handling with write-back.
module msi_coherence_ctrl
   import msi_pkg::*;
#(
   parameter  int NUM_LINES = 4,
   localparam int INDEX_W   = $clog2(NUM_LINES)
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               cpu_valid,
   input  logic               cpu_write,
   input  logic [INDEX_W-1:0] cpu_index,
   output logic               cpu_ready,
   output logic               cpu_done,
   output logic               cpu_hit,
   output logic               bus_req,
   output logic [1:0]         bus_req_op,
   output logic [INDEX_W-1:0] bus_req_index,
   input  logic               bus_grant,
   input  logic               bus_valid,
   input  logic [1:0]         bus_op,
   input  logic [INDEX_W-1:0] bus_index,
   output logic               wb_valid,
   output logic [INDEX_W-1:0] wb_index,
   output logic               proto_err,
   input  logic [INDEX_W-1:0] dbg_index,
   output logic [1:0]         dbg_state
);

   line_state_t        lines      [NUM_LINES];
   line_state_t        lines_next [NUM_LINES];
   ctrl_state_t        state, state_next;
   logic [INDEX_W-1:0] req_index, req_index_next;
   logic               req_write, req_write_next;
   logic               done_next, hit_next, wb_next, perr_next;

   logic [1:0]         snp_next_raw;
   logic               snp_wb, snp_err;
   logic               snoop_apply, grant_take;
   line_state_t        cpu_line;
   logic               cpu_hit_now;

   msi_snoop_next u_snoop (
      .cur_state  (lines[bus_index]),
      .op         (bus_op),
      .next_state (snp_next_raw),
      .wb         (snp_wb),
      .err        (snp_err)
   );

   // A grant in the same cycle as a snoop wins; the snoop is dropped entirely.
   assign snoop_apply = bus_valid & ~bus_grant;
   assign grant_take  = bus_grant & (state == REQ);

   always_comb begin
      for (int unsigned i = 0; i < NUM_LINES; i++) begin
         lines_next[i] = lines[i];
         if (snoop_apply && bus_index == INDEX_W'(i))
            lines_next[i] = line_state_t'(snp_next_raw);
         if (grant_take && req_index == INDEX_W'(i))
            lines_next[i] = req_write ? MODIFIED : SHARED;
      end
   end

   // In IDLE no grant is taken, so lines_next is exactly the post-snoop view.
   assign cpu_line    = lines_next[cpu_index];
   assign cpu_hit_now = cpu_write ? (cpu_line == MODIFIED) : (cpu_line != INVALID);

   always_comb begin
      state_next     = state;
      req_index_next = req_index;
      req_write_next = req_write;
      done_next      = 1'b0;
      hit_next       = 1'b0;
      case (state)
         IDLE: begin
            if (cpu_valid) begin
               if (cpu_hit_now) begin
                  done_next = 1'b1;
                  hit_next  = 1'b1;
               end else begin
                  state_next     = REQ;
                  req_index_next = cpu_index;
                  req_write_next = cpu_write;
               end
            end
         end
         REQ: begin
            if (bus_grant) begin
               done_next  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign wb_next   = snoop_apply & snp_wb;
   assign perr_next = (bus_grant & bus_valid)
                    | (bus_grant & (state != REQ))
                    | (snoop_apply & snp_err);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         req_index <= '0;
         req_write <= 1'b0;
         cpu_done  <= 1'b0;
         cpu_hit   <= 1'b0;
         wb_valid  <= 1'b0;
         wb_index  <= '0;
         proto_err <= 1'b0;
         for (int unsigned i = 0; i < NUM_LINES; i++)
            lines[i] <= INVALID;
      end else begin
         state     <= state_next;
         req_index <= req_index_next;
         req_write <= req_write_next;
         cpu_done  <= done_next;
         cpu_hit   <= hit_next;
         wb_valid  <= wb_next;
         proto_err <= perr_next;
         if (wb_next)
            wb_index <= bus_index;
         for (int unsigned i = 0; i < NUM_LINES; i++)
            lines[i] <= lines_next[i];
      end
   end

   assign cpu_ready     = (state == IDLE);
   assign bus_req       = (state == REQ);
   assign bus_req_op    = bus_req ? miss_op(lines[req_index], req_write) : '0;
   assign bus_req_index = bus_req ? req_index : '0;
   assign dbg_state     = lines[dbg_index];

endmodule

// File: tb/tb_msi_coherence_ctrl.sv
// Self-checking bench: directed vector table, a reset-in-REQ sequence, and
// randomized traffic checked against a rule-level MSI model.
module tb_msi_coherence_ctrl;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       cpu_valid = 1'b0, cpu_write = 1'b0;
   logic [1:0] cpu_index = '0;
   logic       cpu_ready, cpu_done, cpu_hit, bus_req;
   logic [1:0] bus_req_op, bus_req_index;
   logic       bus_grant = 1'b0, bus_valid = 1'b0;
   logic [1:0] bus_op = '0, bus_index = '0;
   logic       wb_valid;
   logic [1:0] wb_index;
   logic       proto_err;
   logic [1:0] dbg_index = '0;
   logic [1:0] dbg_state;

   int checks = 0;
   int errors = 0;

   msi_coherence_ctrl #(.NUM_LINES(4)) dut (
      .clock         (clock),
      .resetn        (resetn),
      .cpu_valid     (cpu_valid),
      .cpu_write     (cpu_write),
      .cpu_index     (cpu_index),
      .cpu_ready     (cpu_ready),
      .cpu_done      (cpu_done),
      .cpu_hit       (cpu_hit),
      .bus_req       (bus_req),
      .bus_req_op    (bus_req_op),
      .bus_req_index (bus_req_index),
      .bus_grant     (bus_grant),
      .bus_valid     (bus_valid),
      .bus_op        (bus_op),
      .bus_index     (bus_index),
      .wb_valid      (wb_valid),
      .wb_index      (wb_index),
      .proto_err     (proto_err),
      .dbg_index     (dbg_index),
      .dbg_state     (dbg_state)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   typedef struct {
      logic       cv, cw;
      logic [1:0] ci;
      logic       g, bv;
      logic [1:0] bo, bi, di;
      logic       rdy, done, hit, req;
      logic [1:0] op, ridx;
      logic       wbv;
      logic [1:0] wbi;
      logic       perr;
      logic [1:0] dst;
   } vec_t;

   vec_t vecs [33];

   // Reference model: line states as plain integers 0=I,1=S,2=M.
   int m_st [4];
   int m_pend, m_pidx, m_pwr;
   int m_done, m_hit, m_wbv, m_wbi, m_perr;

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_st[i] = 0;
      m_pend = 0; m_pidx = 0; m_pwr = 0;
      m_done = 0; m_hit = 0; m_wbv = 0; m_wbi = 0; m_perr = 0;
   endtask

   task automatic model_step();
      int snoop_ok, s, was_pend, want;
      snoop_ok = (bus_valid && !bus_grant) ? 1 : 0;
      was_pend = m_pend;
      m_perr = 0;
      m_wbv  = 0;
      if (bus_grant && bus_valid) m_perr = 1;
      if (bus_grant && !was_pend) m_perr = 1;
      if (snoop_ok) begin
         s = m_st[bus_index];
         if (bus_op == 3) m_perr = 1;
         else if (s == 2 && bus_op == 1) m_perr = 1;
         else if (s == 2) begin
            m_st[bus_index] = (bus_op == 0) ? 1 : 0;
            m_wbv = 1;
            m_wbi = bus_index;
         end else if (s == 1 && bus_op != 0) m_st[bus_index] = 0;
      end
      m_done = 0;
      m_hit  = 0;
      if (was_pend && bus_grant) begin
         m_st[m_pidx] = m_pwr ? 2 : 1;
         m_done = 1;
         m_pend = 0;
      end else if (!was_pend && cpu_valid) begin
         want = cpu_write ? 2 : 1;
         if (m_st[cpu_index] >= want) begin
            m_done = 1;
            m_hit  = 1;
         end else begin
            m_pend = 1;
            m_pidx = cpu_index;
            m_pwr  = cpu_write;
         end
      end
   endtask

   function automatic int model_op();
      if (!m_pend) return 0;
      if (!m_pwr) return 0;
      return (m_st[m_pidx] == 1) ? 1 : 2;
   endfunction

   initial begin
      //          cv cw ci g  bv bo bi di   rdy dn ht rq op ri wv wi pe ds
      vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 2,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 3,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vecs[4]  = '{1, 0, 2, 0, 0, 0, 0, 2,  0, 0, 0, 1, 0, 2, 0, 0, 0, 0};
      vecs[5]  = '{0, 0, 0, 1, 0, 0, 0, 2,  1, 1, 0, 0, 0, 0, 0, 0, 0, 1};
      vecs[6]  = '{1, 0, 1, 0, 0, 0, 0, 1,  0, 0, 0, 1, 0, 1, 0, 0, 0, 0};
      vecs[7]  = '{0, 0, 0, 1, 0, 0, 0, 1,  1, 1, 0, 0, 0, 0, 0, 0, 0, 1};
      vecs[8]  = '{1, 1, 1, 0, 0, 0, 0, 1,  0, 0, 0, 1, 1, 1, 0, 0, 0, 1};
      vecs[9]  = '{0, 0, 0, 1, 0, 0, 0, 1,  1, 1, 0, 0, 0, 0, 0, 0, 0, 2};
      vecs[10] = '{1, 0, 1, 0, 0, 0, 0, 1,  1, 1, 1, 0, 0, 0, 0, 0, 0, 2};
      vecs[11] = '{1, 1, 1, 0, 0, 0, 0, 1,  1, 1, 1, 0, 0, 0, 0, 0, 0, 2};
      vecs[12] = '{1, 1, 3, 0, 0, 0, 0, 3,  0, 0, 0, 1, 2, 3, 0, 0, 0, 0};
      vecs[13] = '{0, 0, 0, 1, 0, 0, 0, 3,  1, 1, 0, 0, 0, 0, 0, 0, 0, 2};
      vecs[14] = '{0, 0, 0, 0, 1, 0, 3, 3,  1, 0, 0, 0, 0, 0, 1, 3, 0, 1};
      vecs[15] = '{0, 0, 0, 0, 1, 2, 3, 3,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vecs[16] = '{1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
      vecs[17] = '{0, 0, 0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 1};
      vecs[18] = '{1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0, 0, 0, 0, 1};
      vecs[19] = '{0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0, 0, 0, 0, 1};
      vecs[20] = '{0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 1, 2, 0, 0, 0, 0, 0};
      vecs[21] = '{0, 0, 0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 2};
      vecs[22] = '{1, 1, 2, 0, 0, 0, 0, 2,  0, 0, 0, 1, 1, 2, 0, 0, 0, 1};
      vecs[23] = '{0, 0, 0, 1, 0, 0, 0, 2,  1, 1, 0, 0, 0, 0, 0, 0, 0, 2};
      vecs[24] = '{1, 0, 2, 0, 1, 2, 2, 2,  0, 0, 0, 1, 0, 2, 1, 2, 0, 0};
      vecs[25] = '{0, 0, 0, 1, 0, 0, 0, 2,  1, 1, 0, 0, 0, 0, 0, 0, 0, 1};
      vecs[26] = '{0, 0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 1, 2};
      vecs[27] = '{0, 0, 0, 0, 1, 3, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 1, 2};
      vecs[28] = '{0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 2};
      vecs[29] = '{1, 1, 3, 0, 0, 0, 0, 3,  0, 0, 0, 1, 2, 3, 0, 0, 0, 0};
      vecs[30] = '{0, 0, 0, 1, 1, 2, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 1, 2};
      vecs[31] = '{0, 0, 0, 0, 0, 0, 0, 3,  1, 0, 0, 0, 0, 0, 0, 0, 0, 2};
      vecs[32] = '{0, 0, 0, 0, 1, 1, 1, 1,  1, 0, 0, 0, 0, 0, 0, 0, 1, 2};

      // Reset state, observed while reset is held.
      #12;
      chk("reset cpu_done", cpu_done, 0);
      chk("reset bus_req", bus_req, 0);
      chk("reset proto_err", proto_err, 0);
      chk("reset wb_valid", wb_valid, 0);
      @(negedge clock);
      resetn = 1'b1;

      for (int k = 0; k < 33; k++) begin
         @(negedge clock);
         cpu_valid = vecs[k].cv; cpu_write = vecs[k].cw; cpu_index = vecs[k].ci;
         bus_grant = vecs[k].g;  bus_valid = vecs[k].bv;
         bus_op    = vecs[k].bo; bus_index = vecs[k].bi; dbg_index = vecs[k].di;
         @(posedge clock);
         #1;
         chk($sformatf("row%0d cpu_ready", k), cpu_ready, vecs[k].rdy);
         chk($sformatf("row%0d cpu_done", k), cpu_done, vecs[k].done);
         chk($sformatf("row%0d cpu_hit", k), cpu_hit, vecs[k].hit);
         chk($sformatf("row%0d bus_req", k), bus_req, vecs[k].req);
         chk($sformatf("row%0d bus_req_op", k), bus_req_op, vecs[k].op);
         chk($sformatf("row%0d bus_req_index", k), bus_req_index, vecs[k].ridx);
         chk($sformatf("row%0d wb_valid", k), wb_valid, vecs[k].wbv);
         if (vecs[k].wbv)
            chk($sformatf("row%0d wb_index", k), wb_index, vecs[k].wbi);
         chk($sformatf("row%0d proto_err", k), proto_err, vecs[k].perr);
         chk($sformatf("row%0d dbg_state", k), dbg_state, vecs[k].dst);
      end

      // Reset while a request is pending: line 2 is SHARED, so a write misses.
      @(negedge clock);
      cpu_valid = 1; cpu_write = 1; cpu_index = 2;
      bus_grant = 0; bus_valid = 0;
      @(posedge clock);
      #1;
      chk("pre-reset in REQ", bus_req, 1);
      chk("pre-reset op", bus_req_op, 1);
      @(negedge clock);
      cpu_valid = 0;
      #2 resetn = 1'b0;
      #1;
      chk("midreset cpu_ready", cpu_ready, 1);
      chk("midreset cpu_done", cpu_done, 0);
      chk("midreset cpu_hit", cpu_hit, 0);
      chk("midreset bus_req", bus_req, 0);
      chk("midreset bus_req_op", bus_req_op, 0);
      chk("midreset bus_req_index", bus_req_index, 0);
      chk("midreset wb_valid", wb_valid, 0);
      chk("midreset wb_index", wb_index, 0);
      chk("midreset proto_err", proto_err, 0);
      for (int i = 0; i < 4; i++) begin
         dbg_index = 2'(i);
         #1;
         chk($sformatf("midreset line%0d", i), dbg_state, 0);
      end
      @(negedge clock);
      resetn = 1'b1;
      bus_grant = 1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clock);
         #1;
         chk($sformatf("postreset cyc%0d cpu_done", c), cpu_done, 0);
         chk($sformatf("postreset cyc%0d bus_req", c), bus_req, 0);
         @(negedge clock);
         bus_grant = 0;
      end

      // Randomized traffic against the model; DUT lines are all INVALID here.
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clock);
         cpu_valid = ($urandom_range(0, 1) == 1);
         cpu_write = ($urandom_range(0, 1) == 1);
         cpu_index = 2'($urandom_range(0, 3));
         bus_grant = ($urandom_range(0, 3) == 0);
         bus_valid = ($urandom_range(0, 2) == 0);
         bus_op    = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         bus_index = 2'($urandom_range(0, 3));
         dbg_index = 2'($urandom_range(0, 3));
         @(posedge clock);
         model_step();
         #1;
         chk($sformatf("rand%0d cpu_ready", c), cpu_ready, (m_pend == 0) ? 1 : 0);
         chk($sformatf("rand%0d bus_req", c), bus_req, m_pend);
         chk($sformatf("rand%0d cpu_done", c), cpu_done, m_done);
         chk($sformatf("rand%0d cpu_hit", c), cpu_hit, m_hit);
         chk($sformatf("rand%0d bus_req_op", c), bus_req_op, model_op());
         if (m_pend)
            chk($sformatf("rand%0d bus_req_index", c), bus_req_index, m_pidx);
         chk($sformatf("rand%0d wb_valid", c), wb_valid, m_wbv);
         if (m_wbv)
            chk($sformatf("rand%0d wb_index", c), wb_index, m_wbi);
         chk($sformatf("rand%0d proto_err", c), proto_err, m_perr);
         chk($sformatf("rand%0d dbg_state", c), dbg_state, m_st[dbg_index]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/msi_coherence_ctrl.md
Name: msi_coherence_ctrl

Overview:
Parametrised MSI coherence controller for a private cache with NUM_LINES lines. It tracks one coherence state per line. It serves processor read/write requests and issues READ_MISS / WRITE_MISS / INVALIDATE bus messages through a request/grant handshake. It also snoops bus traffic from other caches and emits write-back commands. It sits between the cache datapath and the shared snooping bus, and replaces the single-line snoop-only state machine.

Parameters:
NUM_LINES, 4, number of tracked cache lines (power of two, >=2)
INDEX_W, $clog2(NUM_LINES), line index width (derived, not overridden)

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
cpu_valid  in  1  processor request present
cpu_write  in  1  1 = write, 0 = read
cpu_index  in  INDEX_W  line addressed by processor
cpu_ready  out  1  controller can accept request (IDLE)
cpu_done  out  1  one-cycle pulse: request completed
cpu_hit  out  1  qualifies cpu_done: 1 = serviced without bus
bus_req  out  1  controller requests bus
bus_req_op  out  2  op to broadcast (valid while bus_req)
bus_req_index  out  INDEX_W  line of pending request
bus_grant  in  1  bus grants this controller (one cycle)
bus_valid  in  1  snooped message from another cache
bus_op  in  2  snooped op
bus_index  in  INDEX_W  snooped line
wb_valid  out  1  one-cycle pulse: write back line wb_index
wb_index  out  INDEX_W  line to write back
proto_err  out  1  one-cycle pulse on protocol violation
dbg_index  in  INDEX_W  debug line select
dbg_state  out  2  state of line dbg_index (combinational)

Behaviour:
- Line states: INVALID=00, SHARED=01, MODIFIED=10. Encoding 11 is never stored.
- Bus ops: READ_MISS=00, INVALIDATE=01, WRITE_MISS=10. Op 11 is reserved: snoop ignored, proto_err pulsed.
- Reset (async, resetn=0): all lines INVALID. Controller FSM enters IDLE. cpu_done, cpu_hit, bus_req, wb_valid and proto_err are all 0. bus_req_op, bus_req_index and wb_index are 0.
- Reset mid-transaction: the pending request is dropped and no cpu_done is issued.
- Controller FSM has two states, IDLE and REQ. cpu_ready=1 only in IDLE.
- In IDLE with cpu_valid, the request is classified against the post-snoop state of that cycle:
  - Read of SHARED or MODIFIED line: hit.
  - Write of MODIFIED line: hit.
  - Hit response: next cycle cpu_done=1, cpu_hit=1; state unchanged; stay in IDLE.
  - Anything else: latch index and write flag, go to REQ.
- REQ: bus_req=1, bus_req_index = latched index. bus_req_op is derived each cycle from the current state of the latched line:
  - INVALID and read: READ_MISS
  - INVALID and write: WRITE_MISS
  - SHARED and write: INVALIDATE
  - If a snoop invalidates the line while waiting, the op changes from INVALIDATE to WRITE_MISS.
- On bus_grant in REQ:
  - Line becomes SHARED (read) or MODIFIED (write).
  - Next cycle cpu_done=1, cpu_hit=0; return to IDLE.
  - Minimum miss latency is 2 cycles from acceptance.
- Snoop (bus_valid), applied in any FSM state to line bus_index:
  - MODIFIED + READ_MISS: SHARED, write-back.
  - MODIFIED + WRITE_MISS: INVALID, write-back.
  - MODIFIED + INVALIDATE: hold, proto_err.
  - SHARED + READ_MISS: hold.
  - SHARED + WRITE_MISS or INVALIDATE: INVALID.
  - INVALID: hold.
- Write-back: wb_valid pulses one cycle after the snoop, and wb_index = snooped index.
- bus_grant and bus_valid in the same cycle is a violation: grant is processed, snoop ignored, proto_err pulsed.
- bus_grant outside REQ: ignored, proto_err pulsed.
- A snoop and a CPU hit on the same index in the same cycle: the snoop is applied first, and the CPU sees the resulting state. Example: a read of a line that a WRITE_MISS snoop makes INVALID becomes a miss.
- Outputs cpu_done, cpu_hit, wb_valid, wb_index and proto_err are registered. bus_req_op and dbg_state are combinational.

Decomposition:
- msi_pkg holds: line-state enum (INVALID/SHARED/MODIFIED), bus-op enum (READ_MISS/INVALIDATE/WRITE_MISS/RESERVED), controller FSM enum (IDLE/REQ).
- One combinational sub-module, msi_snoop_next: inputs current state and bus_op; outputs next state, wb flag and err flag.
- The controller instantiates msi_snoop_next once, on the bus_index line.

Test Plan:
- Reset, then dbg_state for all 4 lines -> 00. Read line 2, grant at cycle 3 -> bus_req_op=00, line 2 = 01, cpu_done=1 with cpu_hit=0.
- Line 1 SHARED, CPU write to line 1 -> bus_req_op=01. Grant -> line 1 = 10. Then read line 1 -> cpu_done with cpu_hit=1 the next cycle, no bus_req.
- Line 3 MODIFIED, snoop READ_MISS on line 3 -> line 3 = 01, and wb_valid=1 with wb_index=3 exactly one cycle later. Then snoop WRITE_MISS on line 3 -> line 3 = 00, no wb.
- Line 0 SHARED, CPU write pending without grant, snoop INVALIDATE on line 0 -> bus_req_op changes from 01 to 10. Grant -> line 0 = 10.
- Same cycle: CPU read line 2 (MODIFIED) and snoop WRITE_MISS on line 2 -> wb_valid for index 2, and the CPU request becomes a miss issuing READ_MISS.
- bus_grant together with bus_valid, grant while IDLE, and bus_op=11 -> each produces a single proto_err pulse, with the state changes defined above.
- Assert resetn low while in REQ -> all outputs 0 immediately, all lines INVALID, no cpu_done after release.
